// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the registered-ALU command sequencer.
// Optional feature macro: ALU_CHAIN_EN (adds a per-command chain bit to each FIFO entry).
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_e;

    // Opcodes, kept aligned with the registered ALU decoder
    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;

    localparam int unsigned OP_W = 3;

`ifdef ALU_CHAIN_EN
    localparam int unsigned CHAIN_W = 1;
`else
    localparam int unsigned CHAIN_W = 0;
`endif

    // Packed FIFO entry width: {chain (optional), op, b, a}
    function automatic int unsigned cmd_entry_w(input int unsigned width);
        return 2 * width + OP_W + CHAIN_W;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// Full/empty derive from the registered count only, so a push is never
// accepted in the same cycle the FIFO reports full.
module alu_cmd_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap modulo DEPTH) and count
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the registered ALU: buffers commands, issues each to the ALU
// with a one-cycle enable, captures the registered result and returns it.
// Optional feature macro: ALU_CHAIN_EN (chain=1 substitutes last captured result for A).
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic [2:0]       cmd_op_i,
    input  logic             cmd_chain_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    output logic             alu_en_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);

    localparam int unsigned ENTRY_W = cmd_entry_w(WIDTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    seq_state_e         state_q, state_d;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   unused_fifo_count;
    logic               capture;

    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic [2:0]         head_op;

    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2:0]         op_op_q, op_op_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;

`ifdef ALU_CHAIN_EN
    logic               head_chain;
    assign fifo_din   = {cmd_chain_i, cmd_op_i, cmd_b_i, cmd_a_i};
    assign head_chain = fifo_dout[2*WIDTH+3];
`else
    logic               unused_chain;
    assign fifo_din     = {cmd_op_i, cmd_b_i, cmd_a_i};
    assign unused_chain = cmd_chain_i;
`endif

    assign head_a  = fifo_dout[WIDTH-1:0];
    assign head_b  = fifo_dout[2*WIDTH-1:WIDTH];
    assign head_op = fifo_dout[2*WIDTH+2:2*WIDTH];

    assign cmd_ready_o = !fifo_full;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;

    alu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE -> ISSUE -> CAPTURE -> RESP, back-to-back from RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: head pop on entry to ISSUE, ALU enable, capture strobe, response valid
    always_comb begin
        fifo_pop    = 1'b0;
        alu_en_o    = 1'b0;
        capture     = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE:    fifo_pop = !fifo_empty;
            ISSUE:   alu_en_o = 1'b1;
            CAPTURE: capture = 1'b1;
            RESP: begin
                rsp_valid_o = 1'b1;
                fifo_pop    = rsp_ready_i && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Operand regs load on pop (and then hold); response regs load in CAPTURE
    always_comb begin
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_op_d      = op_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        if (fifo_pop) begin
`ifdef ALU_CHAIN_EN
            // rsp_result_q still holds the previous command's result at this edge
            op_a_d = head_chain ? rsp_result_q : head_a;
`else
            op_a_d = head_a;
`endif
            op_b_d  = head_b;
            op_op_d = head_op;
        end
        if (capture) begin
            rsp_result_d = alu_result_i;
            rsp_zero_d   = alu_zero_i;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_op_q      <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_op_q      <= op_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_a_o      = op_a_q;
    assign alu_b_o      = op_b_q;
    assign alu_op_o     = op_op_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign busy_o       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural registered ALU alongside it.
// Honours ALU_CHAIN_EN in its reference model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [2:0]       cmd_op = '0;
    logic             cmd_chain = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             busy;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .cmd_op_i     (cmd_op),
        .cmd_chain_i  (cmd_chain),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_en_o     (alu_en),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .busy_o       (busy)
    );

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        case (op)
            ALU_OP_ADD: return a + b;
            ALU_OP_SUB: return a - b;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            default:    return a ^ b;
        endcase
    endfunction

    // Registered ALU stand-in: result/zero update on en
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            alu_result <= '0;
            alu_zero   <= 1'b0;
        end else if (alu_en) begin
            alu_result <= alu_fn(alu_a, alu_b, alu_op);
            alu_zero   <= (alu_fn(alu_a, alu_b, alu_op) == '0);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected responses in command order
    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
    } rsp_t;

    rsp_t             exp_q[$];
    rsp_t             exp_e;
    logic [WIDTH-1:0] model_last = '0;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] r_eff;
    int               cmd_seen = 0;
    int               rsp_seen = 0;
    logic             hold_valid = 1'b0;
    logic [8:0]       held = '0;
    logic             prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_i) begin
            exp_q.delete();
            model_last = '0;
            hold_valid = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (hold_valid) begin
                check_eq("hold_valid", rsp_valid, 1);
                check_eq("hold_data", {rsp_zero, rsp_result}, held);
            end
            if (alu_en) check_eq("en_pulse_width", prev_en, 0);
            prev_en = alu_en;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", rsp_valid, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("rsp_result", rsp_result, exp_e.res);
                    check_eq("rsp_zero", rsp_zero, exp_e.zero);
                    rsp_seen++;
                end
            end
            hold_valid = rsp_valid && !rsp_ready;
            held       = {rsp_zero, rsp_result};
            if (cmd_valid && cmd_ready) begin
                a_eff = cmd_a;
`ifdef ALU_CHAIN_EN
                if (cmd_chain) a_eff = model_last;
`endif
                r_eff      = alu_fn(a_eff, cmd_b, cmd_op);
                model_last = r_eff;
                exp_q.push_back('{res: r_eff, zero: (r_eff == '0)});
                cmd_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2:0] op, input logic chain);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_chain = chain;
        for (int i = 0; i < 50; i++) begin
            ok = cmd_ready;
            tick();
            if (ok) break;
        end
        cmd_valid = 1'b0;
        if (!ok) check_eq("cmd_accept_timeout", ok, 1);
    endtask

    task automatic wait_rsp(input string tag);
        logic seen;
        seen = rsp_valid;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = rsp_valid;
        end
        check_eq(tag, seen, 1);
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic drain();
        logic done;
        rsp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && !busy;
        end
        check_eq("drain_done", done, 1);
    endtask

    logic saw;
    int   acc;
    int   cmd_base;
    int   rsp_base;
    logic ok2;

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_alu_en", alu_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_data", {rsp_zero, rsp_result}, 0);
        check_eq("rst_alu_ops", {alu_op, alu_b, alu_a}, 0);
        rst_i = 1'b1;
        tick();

        // Reset asserted while a command is in ISSUE
        send_cmd(8'h11, 8'h22, ALU_OP_ADD, 1'b0);
        tick();
        check_eq("t1_issue_en", alu_en, 1);
        rst_i = 1'b0;
        #1;
        check_eq("t1_rst_en", alu_en, 0);
        check_eq("t1_rst_valid", rsp_valid, 0);
        check_eq("t1_rst_ready", cmd_ready, 1);
        check_eq("t1_rst_busy", busy, 0);
        check_eq("t1_rst_alu_a", alu_a, 0);
        tick();
        tick();
        rst_i = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw = saw | rsp_valid | busy;
        end
        check_eq("t1_no_rsp_after_rst", saw, 0);

        // Single ADD: latency of three edges from accept
        send_cmd(8'h05, 8'h03, ALU_OP_ADD, 1'b0);
        check_eq("t2_n0_en", alu_en, 0);
        tick();
        check_eq("t2_n1_en", alu_en, 1);
        check_eq("t2_n1_ab", {alu_b, alu_a}, 16'h0305);
        tick();
        check_eq("t2_n2_en", alu_en, 0);
        check_eq("t2_n2_valid", rsp_valid, 0);
        tick();
        check_eq("t2_n3_valid", rsp_valid, 1);
        check_eq("t2_result", rsp_result, 8'h08);
        check_eq("t2_zero", rsp_zero, 0);
        accept_rsp();

        // SUB giving zero
        send_cmd(8'h2A, 8'h2A, ALU_OP_SUB, 1'b0);
        wait_rsp("t3_wait");
        check_eq("t3_result", rsp_result, 8'h00);
        check_eq("t3_zero", rsp_zero, 1);
        accept_rsp();
        tick();

        // Fill: one command in flight plus DEPTH buffered, next one stalls
        cmd_base  = cmd_seen;
        rsp_base  = rsp_seen;
        acc       = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_a  = WIDTH'($urandom);
            cmd_b  = WIDTH'($urandom);
            cmd_op = 3'($urandom_range(0, 3));
            if (!cmd_ready) break;
            tick();
            acc++;
        end
        check_eq("t4_accepted", acc, DEPTH + 1);
        repeat (3) tick();
        check_eq("t4_stall_ready", cmd_ready, 0);
        check_eq("t4_busy", busy, 1);
        rsp_ready = 1'b1;
        ok2 = 1'b0;
        for (int i = 0; i < 20 && !ok2; i++) begin
            ok2 = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("t4_stalled_accepted", ok2, 1);
        drain();
        check_eq("t4_rsp_count", rsp_seen - rsp_base, DEPTH + 2);
        rsp_ready = 1'b0;

        // Chained accumulation
        send_cmd(8'h10, 8'h01, ALU_OP_ADD, 1'b0);
        wait_rsp("t6_wait1");
        check_eq("t6_first", rsp_result, 8'h11);
        accept_rsp();
        send_cmd(8'h40, 8'h02, ALU_OP_ADD, 1'b1);
        wait_rsp("t6_wait2");
`ifdef ALU_CHAIN_EN
        check_eq("t6_chained", rsp_result, 8'h13);
`else
        check_eq("t6_unchained", rsp_result, 8'h42);
`endif
        accept_rsp();

        // Random traffic with random backpressure
        cmd_base = cmd_seen;
        rsp_base = rsp_seen;
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom);
            cmd_a     = WIDTH'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : WIDTH'($urandom);
            cmd_op    = 3'($urandom_range(0, 3));
            cmd_chain = 1'($urandom);
            rsp_ready = 1'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        drain();
        check_eq("t5_count", rsp_seen - rsp_base, cmd_seen - cmd_base);
        check_eq("t5_queue_empty", exp_q.size(), 0);
        check_eq("t5_idle_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule
